// File: rtl/lcd_spi_pkg.sv
`default_nettype none
// ============================================================================
// Package     : lcd_spi_pkg
// Description : Shared command codes and decoder state encoding for the
//               ST7789-style SPI LCD receive model.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_spi_pkg;

    localparam logic [7:0] CMD_SLPIN   = 8'h10;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_RASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CASET = 3'd1,
        ST_RASET = 3'd2,
        ST_RAMWR = 3'd3,
        ST_SKIP  = 3'd4
    } dec_state_t;

endpackage
`default_nettype wire

// File: rtl/lcd_spi_sink_if.sv
`default_nettype none
// ============================================================================
// Interface   : lcd_spi_sink_if
// Description : 4-wire SPI LCD bus (SCLK, CS, DC/RS, SDA). The master modport
//               drives the bus, the slave modport observes it.
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd_spi_sink_if;
    logic lcd_clk;
    logic lcd_cs;
    logic lcd_rs;
    logic lcd_data;

    modport master (output lcd_clk, output lcd_cs, output lcd_rs, output lcd_data);
    modport slave  (input  lcd_clk, input  lcd_cs, input  lcd_rs, input  lcd_data);
endinterface
`default_nettype wire

// File: rtl/lcd_spi_deser.sv
`default_nettype none
// ============================================================================
// Module      : lcd_spi_deser
// Description : Synchronises the SPI pins into clk, detects SCLK rising edges,
//               assembles MSB-first bytes and flags CS-aborted partial bytes.
//               A byte is reported SYNC_STAGES+2 clk cycles after the pin edge.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_spi_deser #(
    parameter int SYNC_STAGES = 2
) (
    input  wire        clk,
    input  wire        resetn,
    input  wire        lcd_clk,
    input  wire        lcd_cs,
    input  wire        lcd_rs,
    input  wire        lcd_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_is_data,
    output logic       frame_err
);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_STAGES-1:0] rs_sync_q,   rs_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q,  sda_sync_d;

    // Edge-detect stage: registered rise pulse with the other pins aligned to it
    logic       sclk_prev_q, sclk_prev_d;
    logic       rise_q,      rise_d;
    logic       cs_q,        cs_d;
    logic       rs_q,        rs_d;
    logic       sda_q,       sda_d;

    // Byte assembly: only 7 bits need holding, the 8th arrives with the pulse
    logic [6:0] shift_q,        shift_d;
    logic [2:0] cnt_q,          cnt_d;
    logic       byte_valid_q,   byte_valid_d;
    logic [7:0] byte_data_q,    byte_data_d;
    logic       byte_is_data_q, byte_is_data_d;
    logic       frame_err_q,    frame_err_d;

    // Next-state: synchroniser shift, edge detection and byte assembly
    always_comb begin
        sclk_sync_d    = {sclk_sync_q[SYNC_STAGES-2:0], lcd_clk};
        cs_sync_d      = {cs_sync_q[SYNC_STAGES-2:0],   lcd_cs};
        rs_sync_d      = {rs_sync_q[SYNC_STAGES-2:0],   lcd_rs};
        sda_sync_d     = {sda_sync_q[SYNC_STAGES-2:0],  lcd_data};

        sclk_prev_d    = sclk_sync_q[SYNC_STAGES-1];
        rise_d         = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
        cs_d           = cs_sync_q[SYNC_STAGES-1];
        rs_d           = rs_sync_q[SYNC_STAGES-1];
        sda_d          = sda_sync_q[SYNC_STAGES-1];

        shift_d        = shift_q;
        cnt_d          = cnt_q;
        byte_valid_d   = 1'b0;
        byte_data_d    = byte_data_q;
        byte_is_data_d = byte_is_data_q;
        frame_err_d    = 1'b0;

        if (cs_q) begin
            // Deselected: drop any partial byte; report it only if bits were pending
            cnt_d       = 3'd0;
            frame_err_d = (cnt_q != 3'd0);
        end else if (rise_q) begin
            shift_d = {shift_q[5:0], sda_q};
            if (cnt_q == 3'd7) begin
                cnt_d          = 3'd0;
                byte_valid_d   = 1'b1;
                byte_data_d    = {shift_q, sda_q};
                byte_is_data_d = rs_q;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    // State registers; CS resets to its inactive level so no edge is seen at release
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sclk_sync_q    <= '0;
            cs_sync_q      <= '1;
            rs_sync_q      <= '0;
            sda_sync_q     <= '0;
            sclk_prev_q    <= 1'b0;
            rise_q         <= 1'b0;
            cs_q           <= 1'b1;
            rs_q           <= 1'b0;
            sda_q          <= 1'b0;
            shift_q        <= '0;
            cnt_q          <= 3'd0;
            byte_valid_q   <= 1'b0;
            byte_data_q    <= 8'h00;
            byte_is_data_q <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            sclk_sync_q    <= sclk_sync_d;
            cs_sync_q      <= cs_sync_d;
            rs_sync_q      <= rs_sync_d;
            sda_sync_q     <= sda_sync_d;
            sclk_prev_q    <= sclk_prev_d;
            rise_q         <= rise_d;
            cs_q           <= cs_d;
            rs_q           <= rs_d;
            sda_q          <= sda_d;
            shift_q        <= shift_d;
            cnt_q          <= cnt_d;
            byte_valid_q   <= byte_valid_d;
            byte_data_q    <= byte_data_d;
            byte_is_data_q <= byte_is_data_d;
            frame_err_q    <= frame_err_d;
        end
    end

    assign byte_valid   = byte_valid_q;
    assign byte_data    = byte_data_q;
    assign byte_is_data = byte_is_data_q;
    assign frame_err    = frame_err_q;

endmodule
`default_nettype wire

// File: rtl/lcd_spi_sink.sv
`default_nettype none
// ============================================================================
// Module      : lcd_spi_sink
// Description : Receive-side model of an ST7789-style SPI LCD. Decodes the
//               command/parameter stream, tracks the CASET/RASET window and
//               emits one RGB565 pixel write per completed RAMWR pixel.
//               Optional: define LCD_SINK_STATS_EN for saturating 32-bit
//               command/pixel/error counters.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_spi_sink
    import lcd_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int COORD_W     = 9,
    parameter int COL_MAX     = 239,
    parameter int ROW_MAX     = 319
) (
    input  wire                clk,
    input  wire                resetn,
    lcd_spi_sink_if.slave      lcd,
    output logic               byte_valid,
    output logic [7:0]         byte_data,
    output logic               byte_is_data,
    output logic               pixel_valid,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic [15:0]        pixel_rgb,
    output logic               sleep_out,
    output logic               disp_on,
    output logic               frame_err
`ifdef LCD_SINK_STATS_EN
    ,
    output logic [31:0]        cmd_count,
    output logic [31:0]        pixel_count,
    output logic [31:0]        err_count
`endif
);

    localparam logic [COORD_W-1:0] c_coord_one = {{(COORD_W-1){1'b0}}, 1'b1};
    localparam logic [COORD_W-1:0] c_col_max   = COL_MAX[COORD_W-1:0];
    localparam logic [COORD_W-1:0] c_row_max   = ROW_MAX[COORD_W-1:0];

    logic       byte_valid_w;
    logic [7:0] byte_data_w;
    logic       byte_is_data_w;
    logic       frame_err_w;
    logic       pixel_valid_w;

    dec_state_t         state_q, state_d;
    logic [1:0]         pcnt_q, pcnt_d;
    logic [7:0]         start_hi_q, start_hi_d;
    logic [7:0]         start_lo_q, start_lo_d;
    logic [7:0]         end_hi_q, end_hi_d;
    logic [COORD_W-1:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
    logic               half_q, half_d;
    logic [7:0]         hi_q, hi_d;
    logic               sleep_q, sleep_d;
    logic               disp_q, disp_d;
    logic [15:0]        start_w, end_w;
    logic               unused_w;

    lcd_spi_deser #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_deser (
        .clk          (clk),
        .resetn       (resetn),
        .lcd_clk      (lcd.lcd_clk),
        .lcd_cs       (lcd.lcd_cs),
        .lcd_rs       (lcd.lcd_rs),
        .lcd_data     (lcd.lcd_data),
        .byte_valid   (byte_valid_w),
        .byte_data    (byte_data_w),
        .byte_is_data (byte_is_data_w),
        .frame_err    (frame_err_w)
    );

    // Full 16-bit window values; only the low COORD_W bits are kept
    assign start_w  = {start_hi_q, start_lo_q};
    assign end_w    = {end_hi_q, byte_data_w};
    assign unused_w = ^{start_w, end_w};

    // Decoder next-state, window/cursor update and pixel emission
    always_comb begin
        state_d       = state_q;
        pcnt_d        = pcnt_q;
        start_hi_d    = start_hi_q;
        start_lo_d    = start_lo_q;
        end_hi_d      = end_hi_q;
        xs_d          = xs_q;
        xe_d          = xe_q;
        ys_d          = ys_q;
        ye_d          = ye_q;
        cx_d          = cx_q;
        cy_d          = cy_q;
        half_d        = half_q;
        hi_d          = hi_q;
        sleep_d       = sleep_q;
        disp_d        = disp_q;
        pixel_valid_w = 1'b0;

        if (byte_valid_w) begin
            if (!byte_is_data_w) begin
                // Any command restarts decoding and drops a pending high byte
                pcnt_d = 2'd0;
                half_d = 1'b0;
                case (byte_data_w)
                    CMD_CASET: state_d = ST_CASET;
                    CMD_RASET: state_d = ST_RASET;
                    CMD_RAMWR: begin
                        state_d = ST_RAMWR;
                        cx_d    = xs_q;
                        cy_d    = ys_q;
                    end
                    CMD_SLPIN: begin
                        sleep_d = 1'b0;
                        state_d = ST_SKIP;
                    end
                    CMD_SLPOUT: begin
                        sleep_d = 1'b1;
                        state_d = ST_SKIP;
                    end
                    CMD_DISPOFF: begin
                        disp_d  = 1'b0;
                        state_d = ST_SKIP;
                    end
                    CMD_DISPON: begin
                        disp_d  = 1'b1;
                        state_d = ST_SKIP;
                    end
                    default: state_d = ST_SKIP;
                endcase
            end else begin
                case (state_q)
                    ST_CASET, ST_RASET: begin
                        pcnt_d = pcnt_q + 2'd1;
                        case (pcnt_q)
                            2'd0: start_hi_d = byte_data_w;
                            2'd1: start_lo_d = byte_data_w;
                            2'd2: end_hi_d   = byte_data_w;
                            default: begin
                                // Fourth parameter commits the window atomically
                                if (state_q == ST_CASET) begin
                                    xs_d = start_w[COORD_W-1:0];
                                    xe_d = end_w[COORD_W-1:0];
                                end else begin
                                    ys_d = start_w[COORD_W-1:0];
                                    ye_d = end_w[COORD_W-1:0];
                                end
                                state_d = ST_SKIP;
                            end
                        endcase
                    end
                    ST_RAMWR: begin
                        if (!half_q) begin
                            hi_d   = byte_data_w;
                            half_d = 1'b1;
                        end else begin
                            pixel_valid_w = 1'b1;
                            half_d        = 1'b0;
                            // Equality-only compare so inverted windows wrap naturally
                            if (cx_q == xe_q) begin
                                cx_d = xs_q;
                                cy_d = (cy_q == ye_q) ? ys_q : (cy_q + c_coord_one);
                            end else begin
                                cx_d = cx_q + c_coord_one;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Decoder state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Window, cursor, pixel assembly and mode flags
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pcnt_q     <= 2'd0;
            start_hi_q <= 8'h00;
            start_lo_q <= 8'h00;
            end_hi_q   <= 8'h00;
            xs_q       <= '0;
            xe_q       <= c_col_max;
            ys_q       <= '0;
            ye_q       <= c_row_max;
            cx_q       <= '0;
            cy_q       <= '0;
            half_q     <= 1'b0;
            hi_q       <= 8'h00;
            sleep_q    <= 1'b0;
            disp_q     <= 1'b0;
        end else begin
            pcnt_q     <= pcnt_d;
            start_hi_q <= start_hi_d;
            start_lo_q <= start_lo_d;
            end_hi_q   <= end_hi_d;
            xs_q       <= xs_d;
            xe_q       <= xe_d;
            ys_q       <= ys_d;
            ye_q       <= ye_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            half_q     <= half_d;
            hi_q       <= hi_d;
            sleep_q    <= sleep_d;
            disp_q     <= disp_d;
        end
    end

    assign byte_valid   = byte_valid_w;
    assign byte_data    = byte_data_w;
    assign byte_is_data = byte_is_data_w;
    assign frame_err    = frame_err_w;
    assign pixel_valid  = pixel_valid_w;
    assign pixel_x      = cx_q;
    assign pixel_y      = cy_q;
    assign pixel_rgb    = {hi_q, byte_data_w};
    assign sleep_out    = sleep_q;
    assign disp_on      = disp_q;

`ifdef LCD_SINK_STATS_EN
    logic [31:0] cmd_cnt_q, cmd_cnt_d;
    logic [31:0] pix_cnt_q, pix_cnt_d;
    logic [31:0] err_cnt_q, err_cnt_d;

    // Saturating event counters
    always_comb begin
        cmd_cnt_d = cmd_cnt_q;
        pix_cnt_d = pix_cnt_q;
        err_cnt_d = err_cnt_q;
        if (byte_valid_w && !byte_is_data_w && (cmd_cnt_q != 32'hFFFF_FFFF)) begin
            cmd_cnt_d = cmd_cnt_q + 32'd1;
        end
        if (pixel_valid_w && (pix_cnt_q != 32'hFFFF_FFFF)) begin
            pix_cnt_d = pix_cnt_q + 32'd1;
        end
        if (frame_err_w && (err_cnt_q != 32'hFFFF_FFFF)) begin
            err_cnt_d = err_cnt_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cmd_cnt_q <= 32'd0;
            pix_cnt_q <= 32'd0;
            err_cnt_q <= 32'd0;
        end else begin
            cmd_cnt_q <= cmd_cnt_d;
            pix_cnt_q <= pix_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign cmd_count   = cmd_cnt_q;
    assign pixel_count = pix_cnt_q;
    assign err_count   = err_cnt_q;
`endif

endmodule
`default_nettype wire
